// File: rtl/iob_bus_arbiter2_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// iob_bus_arbiter2_pkg: shared encodings and field geometry for the arbiter. Rev 1.0
// ---------------------------------------------------------------------------
package iob_bus_arbiter2_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Replicated across DATA_W to form the rdata returned on a watchdog expiry.
  localparam logic TO_RDATA_FILL = 1'b1;

  // Request layout {valid, addr, wdata, wstrb}; response layout {rdata, ready}.
  function automatic int req_w(input int aw, input int dw);
    return 1 + aw + dw + dw / 8;
  endfunction

  function automatic int resp_w(input int dw);
    return dw + 1;
  endfunction

  function automatic int wd_w(input int t);
    return ($clog2(t + 1) < 1) ? 1 : $clog2(t + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/iob_rr_grant2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// iob_rr_grant2: combinational 2-way round-robin / fixed-priority picker. Rev 1.0
// ---------------------------------------------------------------------------
module iob_rr_grant2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  input  logic       fixed_prio,
  output logic       gnt
);

  always_comb begin
    gnt = 1'b0;
    case (req)
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = fixed_prio ? 1'b0 : ~last_gnt;
      default: gnt = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/iob_bus_arbiter2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// iob_bus_arbiter2: two-master IOb arbiter, one outstanding txn, watchdog. Rev 1.0
// ---------------------------------------------------------------------------
module iob_bus_arbiter2
  import iob_bus_arbiter2_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 1024
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [ADDR_W+DATA_W+DATA_W/8:0]      m0_req,
  output logic [DATA_W:0]                      m0_resp,
  input  logic [ADDR_W+DATA_W+DATA_W/8:0]      m1_req,
  output logic [DATA_W:0]                      m1_resp,
  output logic [ADDR_W+DATA_W+DATA_W/8:0]      s_req,
  input  logic [DATA_W:0]                      s_resp,
  output logic                                 timeout_err
);

  localparam int REQ_W = req_w(ADDR_W, DATA_W);
  localparam int WD_W  = wd_w(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT == 0) ? '0 : WD_W'(TIMEOUT - 1);

  logic [0:0]      state, state_nxt;
  logic            gnt_reg, last_gnt, pick, cur;
  logic [WD_W-1:0] wd_cnt;
  logic [1:0]      valids;
  logic            s_ready, wd_fire, done, ready_out;
  logic [DATA_W-1:0] rdata;

  assign valids  = {m1_req[REQ_W-1], m0_req[REQ_W-1]};
  assign s_ready = s_resp[0];

  iob_rr_grant2 u_pick (
    .req        (valids),
    .last_gnt   (last_gnt),
    .fixed_prio (FIXED_PRIO != 0),
    .gnt        (pick)
  );

  // In IDLE the grant is live (zero-latency forwarding); in BUSY it is latched.
  assign cur     = (state == ST_IDLE) ? pick : gnt_reg;
  assign wd_fire = (TIMEOUT != 0) && (state == ST_BUSY) && (wd_cnt == WD_LAST) && !s_ready;
  assign done    = (state == ST_IDLE) ? ((|valids) && s_ready) : (s_ready || wd_fire);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      gnt_reg  <= 1'b0;
      last_gnt <= 1'b1;
      wd_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && (|valids)) gnt_reg <= pick;
      if (done) last_gnt <= cur;
      if (state == ST_IDLE)  wd_cnt <= '0;
      else if (!s_ready)     wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if ((|valids) && !s_ready) state_nxt = ST_BUSY;
      ST_BUSY: if (s_ready || wd_fire)    state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are gated by rst so they clear asynchronously, not at the next edge.
  always_comb begin
    s_req       = '0;
    m0_resp     = '0;
    m1_resp     = '0;
    timeout_err = 1'b0;
    rdata       = wd_fire ? {DATA_W{TO_RDATA_FILL}} : s_resp[DATA_W:1];
    ready_out   = (state == ST_BUSY) ? (s_ready || wd_fire) : ((|valids) && s_ready);
    if (!rst) begin
      if (state == ST_BUSY || (|valids)) s_req = cur ? m1_req : m0_req;
      if (wd_fire) begin
        s_req[REQ_W-1] = 1'b0;
        timeout_err    = 1'b1;
      end
      m0_resp = {rdata, ready_out && !cur};
      m1_resp = {rdata, ready_out && cur};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iob_bus_arbiter2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_iob_bus_arbiter2: scoreboard bench, round-robin and fixed-priority DUTs. Rev 1.0
// ---------------------------------------------------------------------------
module tb_iob_bus_arbiter2;

  localparam int RW = 69;

  typedef struct {
    int          d;
    logic        m;
    logic [31:0] rdata;
    logic        terr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // index d*2+m : DUT d, master m
  logic        vld[4];
  logic [31:0] adr[4];
  logic [31:0] wdt[4];
  logic [3:0]  stb[4];
  logic        srdy[2];
  logic [31:0] srd[2];

  wire [RW-1:0] m00 = {vld[0], adr[0], wdt[0], stb[0]};
  wire [RW-1:0] m01 = {vld[1], adr[1], wdt[1], stb[1]};
  wire [RW-1:0] m10 = {vld[2], adr[2], wdt[2], stb[2]};
  wire [RW-1:0] m11 = {vld[3], adr[3], wdt[3], stb[3]};
  wire [32:0]   sr0 = {srd[0], srdy[0]};
  wire [32:0]   sr1 = {srd[1], srdy[1]};
  wire [RW-1:0] sreq0, sreq1;
  wire [32:0]   r00, r01, r10, r11;
  wire          te0, te1;

  iob_bus_arbiter2 #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0), .TIMEOUT(8)) dut_rr (
    .clk(clk), .rst(rst), .m0_req(m00), .m0_resp(r00), .m1_req(m01), .m1_resp(r01),
    .s_req(sreq0), .s_resp(sr0), .timeout_err(te0)
  );

  iob_bus_arbiter2 #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1), .TIMEOUT(8)) dut_fp (
    .clk(clk), .rst(rst), .m0_req(m10), .m0_resp(r10), .m1_req(m11), .m1_resp(r11),
    .s_req(sreq1), .s_resp(sr1), .timeout_err(te1)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  function automatic logic [RW-1:0] f_sreq(input int d);
    return (d == 0) ? sreq0 : sreq1;
  endfunction

  function automatic logic [32:0] f_resp(input int d, input int m);
    case (d * 2 + m)
      0:       return r00;
      1:       return r01;
      2:       return r10;
      default: return r11;
    endcase
  endfunction

  function automatic logic f_terr(input int d);
    return (d == 0) ? te0 : te1;
  endfunction

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic master_seq(input int d, input int m, input logic [31:0] base, input int n,
                            input logic [31:0] wd, input logic [3:0] ws);
    int   i;
    logic got;
    i = d * 2 + m;
    @(posedge clk); #1;
    for (int k = 0; k < n; k++) begin
      vld[i] = 1'b1; adr[i] = base + 32'(4 * k); wdt[i] = wd; stb[i] = ws;
      got = 1'b0;
      for (int c = 0; c < 100 && !got; c++) begin
        @(negedge clk);
        got = f_resp(d, m)[0];
        @(posedge clk); #1;
      end
      chk($sformatf("master%0d_%0d_wait", d, m), 80'(got), 80'(1));
    end
    vld[i] = 1'b0;
  endtask

  // Auto slave: ready after lat cycles of a valid request, rdata = 0xD0000000 | addr.
  task automatic slave_auto(input int d, input int lat, input int n);
    int done;
    int w;
    int guard;
    logic [RW-1:0] q;
    done = 0; w = 0; guard = 0;
    while (done < n && guard < 500) begin
      @(posedge clk); #2;
      guard++;
      srdy[d] = 1'b0;
      q = f_sreq(d);
      if (q[68]) begin
        if (w == lat) begin
          srdy[d] = 1'b1; srd[d] = 32'hD000_0000 | q[67:36]; done++; w = 0;
        end else w++;
      end
    end
    chk($sformatf("slave%0d_done", d), 80'(done), 80'(n));
    @(posedge clk); #2 srdy[d] = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  always @(negedge clk) begin : mon
    logic r0, r1, te;
    logic [31:0] rd;
    exp_t e;
    if (rst === 1'b0) begin
      for (int d = 0; d < 2; d++) begin
        r0 = f_resp(d, 0)[0];
        r1 = f_resp(d, 1)[0];
        te = f_terr(d);
        rd = r1 ? f_resp(d, 1)[32:1] : f_resp(d, 0)[32:1];
        if (r0 || r1) begin
          if (exp_q.size() == 0) chk("sb_unexpected_ready", 80'({r0, r1}), 80'(0));
          else begin
            e = exp_q.pop_front();
            chk($sformatf("sb_dut%0d", d), 80'({2'(d), r0, r1, rd, te}),
                80'({2'(e.d), ~e.m, e.m, e.rdata, e.terr}));
          end
        end else if (te) chk("sb_stray_timeout_err", 80'(te), 80'(0));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int pulses;
    int first;
    logic [RW-1:0] q;
    for (int i = 0; i < 4; i++) begin vld[i] = 0; adr[i] = 0; wdt[i] = 0; stb[i] = 0; end
    srdy[0] = 0; srdy[1] = 0; srd[0] = 0; srd[1] = 0;

    // Reset: outputs held at zero even with live inputs.
    rst = 1'b1;
    vld[0] = 1'b1; adr[0] = 32'h123; srdy[0] = 1'b1; srd[0] = 32'hFFFF;
    #2;
    chk("rst_sreq0", 80'(sreq0), 80'(0));
    chk("rst_sreq1", 80'(sreq1), 80'(0));
    chk("rst_m0_resp", 80'(r00), 80'(0));
    chk("rst_terr", 80'(te0), 80'(0));
    vld[0] = 1'b0; adr[0] = 0; srdy[0] = 1'b0; srd[0] = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single m0 read, slave answers two cycles later.
    exp_q.push_back('{0, 1'b0, 32'hCAFE0001, 1'b0});
    fork
      master_seq(0, 0, 32'h100, 1, 32'h0, 4'h0);
      begin
        @(posedge clk); @(posedge clk); @(posedge clk);
        #2 srdy[0] = 1'b1; srd[0] = 32'hCAFE0001;
        @(posedge clk); #2 srdy[0] = 1'b0;
      end
      begin
        @(posedge clk); @(negedge clk);
        chk("single_sreq_idle", 80'(sreq0), 80'({1'b1, 32'h100, 32'h0, 4'h0}));
        @(negedge clk);
        chk("single_sreq_busy", 80'(sreq0), 80'({1'b1, 32'h100, 32'h0, 4'h0}));
      end
    join

    // Round-robin ties.
    apply_reset();
    exp_q.push_back('{0, 1'b0, 32'hD000_0010, 1'b0});
    exp_q.push_back('{0, 1'b1, 32'hD000_0020, 1'b0});
    exp_q.push_back('{0, 1'b0, 32'hD000_0014, 1'b0});
    exp_q.push_back('{0, 1'b1, 32'hD000_0024, 1'b0});
    exp_q.push_back('{0, 1'b0, 32'hD000_0018, 1'b0});
    exp_q.push_back('{0, 1'b1, 32'hD000_0028, 1'b0});
    fork
      master_seq(0, 0, 32'h10, 3, 32'h0, 4'h0);
      master_seq(0, 1, 32'h20, 3, 32'h0, 4'h0);
      slave_auto(0, 1, 6);
    join

    // Fixed priority: all m0 first.
    exp_q.push_back('{1, 1'b0, 32'hD000_0010, 1'b0});
    exp_q.push_back('{1, 1'b0, 32'hD000_0014, 1'b0});
    exp_q.push_back('{1, 1'b0, 32'hD000_0018, 1'b0});
    exp_q.push_back('{1, 1'b1, 32'hD000_0020, 1'b0});
    exp_q.push_back('{1, 1'b1, 32'hD000_0024, 1'b0});
    exp_q.push_back('{1, 1'b1, 32'hD000_0028, 1'b0});
    fork
      master_seq(1, 0, 32'h10, 3, 32'h0, 4'h0);
      master_seq(1, 1, 32'h20, 3, 32'h0, 4'h0);
      slave_auto(1, 1, 6);
    join

    // m1 write holds the slave while m0 arrives.
    exp_q.push_back('{0, 1'b1, 32'hD000_0200, 1'b0});
    exp_q.push_back('{0, 1'b0, 32'hD000_0300, 1'b0});
    fork
      master_seq(0, 1, 32'h200, 1, 32'h12345678, 4'hF);
      begin
        @(posedge clk);
        master_seq(0, 0, 32'h300, 1, 32'h0, 4'h0);
      end
      slave_auto(0, 3, 2);
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("hold_sreq_m1", 80'(sreq0), 80'({1'b1, 32'h200, 32'h12345678, 4'hF}));
        @(negedge clk);
        chk("next_sreq_m0", 80'(sreq0), 80'({1'b1, 32'h300, 32'h0, 4'h0}));
      end
    join

    // Watchdog: silent slave, TIMEOUT=8.
    exp_q.push_back('{0, 1'b0, 32'hFFFF_FFFF, 1'b1});
    pulses = 0; first = -1;
    fork
      master_seq(0, 0, 32'h400, 1, 32'h0, 4'h0);
      begin
        @(posedge clk);
        for (int c = 0; c < 30; c++) begin
          @(negedge clk);
          if (te0) begin
            pulses++;
            if (first < 0) first = c;
            q = sreq0;
            chk("to_sreq_valid", 80'(q[68]), 80'(0));
          end
        end
      end
    join
    chk("to_cycle", 80'(first), 80'(8));
    chk("to_pulses", 80'(pulses), 80'(1));
    exp_q.push_back('{0, 1'b1, 32'hD000_0500, 1'b0});
    fork
      master_seq(0, 1, 32'h500, 1, 32'h0, 4'h0);
      slave_auto(0, 1, 1);
    join

    // Reset in mid-BUSY, then first tie goes to m0.
    @(posedge clk); #1 vld[0] = 1'b1; adr[0] = 32'h600; wdt[0] = 0; stb[0] = 0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_sreq", 80'(sreq0), 80'(0));
    chk("midrst_m0_resp", 80'(r00), 80'(0));
    chk("midrst_m1_resp", 80'(r01), 80'(0));
    chk("midrst_terr", 80'(te0), 80'(0));
    vld[1] = 1'b1; adr[1] = 32'h700; wdt[1] = 0; stb[1] = 0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_first_tie", 80'(sreq0), 80'({1'b1, 32'h600, 32'h0, 4'h0}));
    exp_q.push_back('{0, 1'b0, 32'hD000_0600, 1'b0});
    @(posedge clk); #2 srdy[0] = 1'b1; srd[0] = 32'hD000_0600;
    @(posedge clk); #1 vld[0] = 1'b0; vld[1] = 1'b0;
    #1 srdy[0] = 1'b0;
    repeat (3) @(posedge clk);

    chk("sb_leftover", 80'(exp_q.size()), 80'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
